// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl - run-control unit for the single-cycle RISC-V core.
//
// The core runs on the board clock and commits one instruction for every
// one-clock cpu_en pulse. Pulses come from a selectable prescaler.
// A HALT/RUN/STEP state machine gates the pulses. It is driven by the go
// button, the core's ecall-pause request and a PC breakpoint.
//
// Ports:
//   clk        in   board clock, the only clock in the block
//   rst        in   asynchronous active-low reset
//   go         in   raw go button (asynchronous level)
//   step_mode  in   1: each go press executes exactly one instruction
//   rate_sel   in   step rate select, 0..3 -> DIV0..DIV3
//   halt_req   in   ecall-pause request from the core (combinational)
//   pc         in   current PC from the core
//   bp_en      in   breakpoint enable
//   bp_addr    in   breakpoint PC
//   cpu_en     out  one-clock commit pulse to the core (registered)
//   halted     out  1 while in HALT (registered)
//   halt_cause out  0 reset, 1 ecall, 2 breakpoint, 3 step done, 4 manual
//   cycle_cnt  out  cpu_en pulses since reset, wraps modulo 2^CNT_W
module riscv_run_ctrl #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned DIV0     = 50000000,
   parameter int unsigned DIV1     = 5000000,
   parameter int unsigned DIV2     = 1000000,
   parameter int unsigned DIV3     = 500000,
   parameter bit          AUTO_RUN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             step_mode,
   input  logic [1:0]       rate_sel,
   input  logic             halt_req,
   input  logic [XLEN-1:0]  pc,
   input  logic             bp_en,
   input  logic [XLEN-1:0]  bp_addr,
   output logic             cpu_en,
   output logic             halted,
   output logic [2:0]       halt_cause,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} state_t;

   localparam logic [2:0] CAUSE_RESET  = 3'd0;
   localparam logic [2:0] CAUSE_ECALL  = 3'd1;
   localparam logic [2:0] CAUSE_BP     = 3'd2;
   localparam logic [2:0] CAUSE_STEP   = 3'd3;
   localparam logic [2:0] CAUSE_MANUAL = 3'd4;

   state_t           state_q, state_d;
   logic             cpu_en_q, cpu_en_d;
   logic             halted_q, halted_d;
   logic [2:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic             skip_q, skip_d;
   logic [31:0]      ps_q, ps_d;
   logic [1:0]       rate_q, rate_d;
   logic [2:0]       sync_q, sync_d;

   logic [31:0]      div_sel;
   logic             rate_chg;
   logic             tick;
   logic             stop;
   logic             go_pulse;

   // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the previous
   // synchronised level for edge detection. go_pulse is high in the third
   // clock after the raw edge, and a held button never repeats.
   assign sync_d   = {sync_q[1:0], go};
   assign go_pulse = sync_q[1] & ~sync_q[2];

   always_comb begin
      div_sel = 32'(DIV0);
      case (rate_sel)
         2'd0:    div_sel = 32'(DIV0);
         2'd1:    div_sel = 32'(DIV1);
         2'd2:    div_sel = 32'(DIV2);
         default: div_sel = 32'(DIV3);
      endcase
   end

   // A rate change restarts the prescaler and suppresses the tick in the
   // change clock. This avoids a short first period at the new rate.
   assign rate_chg = (rate_sel != rate_q);
   assign rate_d   = rate_sel;
   assign tick     = (state_q != ST_HALT) && !rate_chg &&
                     (ps_q >= div_sel - 32'd1);

   always_comb begin
      ps_d = ps_q + 32'd1;
      if ((state_q == ST_HALT) || rate_chg || tick) begin
         ps_d = 32'd0;
      end
   end

   assign stop = halt_req | (bp_en & (pc == bp_addr));

   always_comb begin
      state_d  = state_q;
      cpu_en_d = 1'b0;
      cause_d  = cause_q;
      cyc_d    = cyc_q;
      skip_d   = skip_q;
      case (state_q)
         ST_HALT: begin
            // skip lets the first instruction after resume pass, even
            // when it is the ecall or breakpoint that stopped us.
            if (go_pulse) begin
               state_d = step_mode ? ST_STEP : ST_RUN;
               skip_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (go_pulse) begin
               state_d = ST_HALT;
               cause_d = CAUSE_MANUAL;
            end else if (tick && stop && !skip_q) begin
               state_d = ST_HALT;
               cause_d = halt_req ? CAUSE_ECALL : CAUSE_BP;
            end else if (tick) begin
               cpu_en_d = 1'b1;
               cyc_d    = cyc_q + CNT_W'(1);
               skip_d   = 1'b0;
            end
         end
         ST_STEP: begin
            if (go_pulse) begin
               state_d = ST_HALT;
               cause_d = CAUSE_MANUAL;
            end else if (tick) begin
               cpu_en_d = 1'b1;
               cyc_d    = cyc_q + CNT_W'(1);
               skip_d   = 1'b0;
               state_d  = ST_HALT;
               cause_d  = CAUSE_STEP;
            end
         end
         default: state_d = ST_HALT;
      endcase
   end

   assign halted_d = (state_d == ST_HALT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= AUTO_RUN ? ST_RUN : ST_HALT;
         cpu_en_q <= 1'b0;
         halted_q <= !AUTO_RUN;
         cause_q  <= CAUSE_RESET;
         cyc_q    <= '0;
         skip_q   <= 1'b0;
         ps_q     <= 32'd0;
         rate_q   <= 2'd0;
         sync_q   <= 3'd0;
      end else begin
         state_q  <= state_d;
         cpu_en_q <= cpu_en_d;
         halted_q <= halted_d;
         cause_q  <= cause_d;
         cyc_q    <= cyc_d;
         skip_q   <= skip_d;
         ps_q     <= ps_d;
         rate_q   <= rate_d;
         sync_q   <= sync_d;
      end
   end

   assign cpu_en     = cpu_en_q;
   assign halted     = halted_q;
   assign halt_cause = cause_q;
   assign cycle_cnt  = cyc_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Self-checking bench for riscv_run_ctrl. It uses small dividers and a
// 4-bit cycle counter. A tiny core model advances pc by 4 on every cpu_en.
// Each committed instruction is checked against an expected {pc, count}
// queue.
module tb_riscv_run_ctrl;

   localparam int DIV0 = 4;
   localparam int DIV1 = 3;
   localparam int DIV2 = 2;
   localparam int DIV3 = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        go = 1'b0;
   logic        step_mode = 1'b0;
   logic [1:0]  rate_sel = 2'd0;
   logic        halt_req = 1'b0;
   logic [31:0] pc;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = 32'd0;
   logic        cpu_en;
   logic        halted;
   logic [2:0]  halt_cause;
   logic [3:0]  cycle_cnt;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  cnt;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   typedef struct {
      logic [1:0] rate;
      int         first_lat;
      int         period;
   } vec_t;
   vec_t vecs[4];

   riscv_run_ctrl #(
      .XLEN(32), .CNT_W(4), .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2),
      .DIV3(DIV3), .AUTO_RUN(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .go(go), .step_mode(step_mode),
      .rate_sel(rate_sel), .halt_req(halt_req), .pc(pc), .bp_en(bp_en),
      .bp_addr(bp_addr), .cpu_en(cpu_en), .halted(halted),
      .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   // core model: one instruction per cpu_en pulse
   always @(posedge clk or negedge rst) begin
      if (!rst) pc <= 32'd0;
      else if (cpu_en) pc <= pc + 32'd4;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard: every commit must match the oldest expectation
   always @(negedge clk) begin
      if (rst && cpu_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: cpu_en at pc=0x%0h cnt=%0d, none expected", pc, cycle_cnt);
         end else begin
            mon_e = exp_q.pop_front();
            if (pc !== mon_e.pc || cycle_cnt !== mon_e.cnt) begin
               failures++;
               $display("FAIL sb_commit: got pc=0x%0h cnt=%0d want pc=0x%0h cnt=%0d",
                        pc, cycle_cnt, mon_e.pc, mon_e.cnt);
            end
         end
      end
   end

   task automatic push(input logic [31:0] p, input logic [3:0] c);
      exp_t e;
      e.pc = p;
      e.cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      chk("sb_leftover", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      go = 1'b0;
      halt_req = 1'b0;
      bp_en = 1'b0;
      step_mode = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_halted", 32'(halted), 32'd1);
      chk("rst_cpu_en", 32'(cpu_en), 32'd0);
      chk("rst_cause", 32'(halt_cause), 32'd0);
      chk("rst_cnt", 32'(cycle_cnt), 32'd0);
      step();
      step();
      rst = 1'b1;
      step();
      step();
   endtask

   // wait for the next cpu_en; steps = clocks from the call
   task automatic wait_en(input int lim, output int steps);
      steps = 0;
      do begin
         step();
         steps++;
      end while (!cpu_en && steps < lim);
      chk("wait_en_timeout", 32'(cpu_en), 32'd1);
   endtask

   task automatic wait_halted(input int lim);
      int n;
      n = 0;
      while (!halted && n < lim) begin
         step();
         n++;
      end
      chk("wait_halt_timeout", 32'(halted), 32'd1);
   endtask

   task automatic press_go();
      go = 1'b1;
      repeat (4) step();
      go = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0] = '{rate: 2'd0, first_lat: 3 + DIV0, period: DIV0};
      vecs[1] = '{rate: 2'd1, first_lat: 3 + DIV1, period: DIV1};
      vecs[2] = '{rate: 2'd2, first_lat: 3 + DIV2, period: DIV2};
      vecs[3] = '{rate: 2'd3, first_lat: 3 + DIV3, period: DIV3};

      #2;
      do_reset();
      chk("idle_halted", 32'(halted), 32'd1);

      // rate table: first-commit latency from the go edge, then the period
      for (int i = 0; i < 4; i++) begin
         rate_sel = vecs[i].rate;
         do_reset();
         push(32'd0, 4'd1);
         push(32'd4, 4'd2);
         go = 1'b1;
         wait_en(40, n);
         chk($sformatf("tbl%0d_first_lat", i), 32'(n), 32'(vecs[i].first_lat));
         wait_en(40, n);
         chk($sformatf("tbl%0d_period", i), 32'(n), 32'(vecs[i].period));
         chk($sformatf("tbl%0d_running", i), 32'(halted), 32'd0);
         go = 1'b0;
         step();
      end

      // go latency, three commits, manual halt between ticks
      rate_sel = 2'd0;
      do_reset();
      push(32'd0, 4'd1);
      push(32'd4, 4'd2);
      push(32'd8, 4'd3);
      go = 1'b1;
      step();
      step();
      chk("go_lat_still_halted", 32'(halted), 32'd1);
      step();
      chk("go_lat_running", 32'(halted), 32'd0);
      step();
      go = 1'b0;
      wait_en(20, n);
      chk("run_first_en", 32'(n), 32'd3);
      wait_en(20, n);
      chk("run_period_a", 32'(n), 32'(DIV0));
      wait_en(20, n);
      chk("run_period_b", 32'(n), 32'(DIV0));
      press_go();
      chk("man_halted", 32'(halted), 32'd1);
      chk("man_cause", 32'(halt_cause), 32'd4);
      chk("man_cnt", 32'(cycle_cnt), 32'd3);
      chk("man_pc", pc, 32'hC);

      // breakpoint at 0x10, skip on resume, go coincident with tick
      rate_sel = 2'd1;
      do_reset();
      bp_en = 1'b1;
      bp_addr = 32'h10;
      push(32'h0, 4'd1);
      push(32'h4, 4'd2);
      push(32'h8, 4'd3);
      push(32'hC, 4'd4);
      press_go();
      wait_halted(100);
      chk("bp_cause", 32'(halt_cause), 32'd2);
      chk("bp_cnt", 32'(cycle_cnt), 32'd4);
      chk("bp_pc", pc, 32'h10);
      push(32'h10, 4'd5);
      push(32'h14, 4'd6);
      push(32'h18, 4'd7);
      go = 1'b1;
      repeat (4) step();
      go = 1'b0;
      repeat (3) wait_en(20, n);
      // next go_pulse lands in the same clock as the next tick
      press_go();
      chk("coinc_halted", 32'(halted), 32'd1);
      chk("coinc_cause", 32'(halt_cause), 32'd4);
      chk("coinc_cnt", 32'(cycle_cnt), 32'd7);

      // ecall pause, held across resume; ecall beats breakpoint
      rate_sel = 2'd2;
      do_reset();
      halt_req = 1'b1;
      push(32'h0, 4'd1);
      press_go();
      wait_halted(50);
      chk("ecall_cause", 32'(halt_cause), 32'd1);
      chk("ecall_cnt", 32'(cycle_cnt), 32'd1);
      bp_en = 1'b1;
      bp_addr = 32'h8;
      push(32'h4, 4'd2);
      press_go();
      wait_halted(50);
      chk("ecall_bp_cause", 32'(halt_cause), 32'd1);
      chk("ecall_bp_cnt", 32'(cycle_cnt), 32'd2);
      halt_req = 1'b0;
      bp_addr = 32'hC;
      push(32'h8, 4'd3);
      press_go();
      wait_halted(50);
      chk("bp2_cause", 32'(halt_cause), 32'd2);
      chk("bp2_pc", pc, 32'hC);

      // single-step mode
      rate_sel = 2'd2;
      do_reset();
      step_mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(32'(4 * i), 4'(i + 1));
         press_go();
         wait_halted(50);
         chk($sformatf("step%0d_cause", i), 32'(halt_cause), 32'd3);
         chk($sformatf("step%0d_cnt", i), 32'(cycle_cnt), 32'(i + 1));
      end
      step_mode = 1'b0;

      // rate change while running, then reset during a cpu_en pulse
      rate_sel = 2'd0;
      do_reset();
      push(32'h0, 4'd1);
      push(32'h4, 4'd2);
      go = 1'b1;
      wait_en(40, n);
      go = 1'b0;
      rate_sel = 2'd3;
      wait_en(40, n);
      // one suppressed change clock, then a full DIV3 period
      chk("rchg_first", 32'(n), 32'(DIV3 + 1));
      wait_en(40, n);
      chk("rchg_period", 32'(n), 32'(DIV3));
      rst = 1'b0;
      #1;
      chk("arst_cpu_en", 32'(cpu_en), 32'd0);
      chk("arst_cnt", 32'(cycle_cnt), 32'd0);
      chk("arst_cause", 32'(halt_cause), 32'd0);
      chk("arst_halted", 32'(halted), 32'd1);

      // 4-bit counter wraps: 17 commits leave it at 1
      rate_sel = 2'd2;
      do_reset();
      for (int i = 0; i < 17; i++) push(32'(4 * i), 4'((i + 1) % 16));
      go = 1'b1;
      for (int i = 0; i < 17; i++) wait_en(20, n);
      go = 1'b0;
      chk("wrap_cnt", 32'(cycle_cnt), 32'd1);
      step();
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
